// File: rtl/signal_demodulator_if.sv
// Sample-in / packet-out bundle for signal_demodulator.
// The slave modport is the demodulator's view and the master modport is the driver's view.
interface signal_demodulator_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int PACKET_SIZE = 8
);
    logic signed [DATA_WIDTH-1:0] sample_in;
    logic                         sample_valid;
    logic                         resync;
    logic [PACKET_SIZE-1:0]       packet_out;
    logic                         packet_valid;
    logic                         packet_ready;
    logic                         sync_locked;
    logic                         overrun;

    modport master (
        output sample_in, sample_valid, resync, packet_ready,
        input  packet_out, packet_valid, sync_locked, overrun
    );

    modport slave (
        input  sample_in, sample_valid, resync, packet_ready,
        output packet_out, packet_valid, sync_locked, overrun
    );
endinterface

// File: rtl/signal_demodulator.sv
// Integrate-and-dump BPSK demodulator with sync-word hunt and packet assembly.
// Defining DEMOD_DIFFERENTIAL_EN selects DBPSK decoding, where the delivered bit is the decision XOR the previous decision.
module signal_demodulator #(
    parameter int                    DATA_WIDTH      = 8,
    parameter int                    SAMPLES_PER_BIT = 16,
    parameter int                    PACKET_SIZE     = 8,
    parameter int                    SYNC_WIDTH      = 8,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD       = SYNC_WIDTH'(8'hD5)
) (
    input logic clk,
    input logic rst,
    signal_demodulator_if.slave bus
);
    localparam int ACC_W = DATA_WIDTH + $clog2(SAMPLES_PER_BIT) + 1;
    localparam int PH_W  = $clog2(SAMPLES_PER_BIT);
    localparam int CNT_W = $clog2(PACKET_SIZE + 1);

    typedef enum logic {HUNT, COLLECT} state_t;

    logic [PH_W-1:0]         ph_q, ph_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    strobe_q, strobe_d;
    logic                    bit_q, bit_d;
`ifdef DEMOD_DIFFERENTIAL_EN
    logic                    prev_q, prev_d;
`endif
    state_t                  state_q, state_d;
    logic [SYNC_WIDTH-1:0]   sync_q, sync_d;
    logic [PACKET_SIZE-1:0]  pkt_q, pkt_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PACKET_SIZE-1:0]  out_q, out_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;

    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] accSum;
    logic                    decision;
    logic                    deliver;
    logic [SYNC_WIDTH-1:0]   syncNext;
    logic [PACKET_SIZE-1:0]  pktNext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_q      <= '0;
            acc_q     <= '0;
            strobe_q  <= 1'b0;
            bit_q     <= 1'b0;
`ifdef DEMOD_DIFFERENTIAL_EN
            prev_q    <= 1'b0;
`endif
            state_q   <= HUNT;
            sync_q    <= '0;
            pkt_q     <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            ph_q      <= ph_d;
            acc_q     <= acc_d;
            strobe_q  <= strobe_d;
            bit_q     <= bit_d;
`ifdef DEMOD_DIFFERENTIAL_EN
            prev_q    <= prev_d;
`endif
            state_q   <= state_d;
            sync_q    <= sync_d;
            pkt_q     <= pkt_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // Correlate against a square carrier: +sample in the first half-symbol, -sample in the second.
    always_comb begin
        ph_d     = ph_q;
        acc_d    = acc_q;
        strobe_d = 1'b0;
        bit_d    = bit_q;
`ifdef DEMOD_DIFFERENTIAL_EN
        prev_d   = prev_q;
`endif
        term     = {{(ACC_W-DATA_WIDTH){bus.sample_in[DATA_WIDTH-1]}}, bus.sample_in};
        if (ph_q >= PH_W'(SAMPLES_PER_BIT/2))
            term = -term;
        accSum   = acc_q + term;
        decision = !accSum[ACC_W-1] && (accSum != '0);

        if (bus.resync) begin
            ph_d  = '0;
            acc_d = '0;
`ifdef DEMOD_DIFFERENTIAL_EN
            prev_d = 1'b0;
`endif
        end else if (bus.sample_valid) begin
            if (ph_q == PH_W'(SAMPLES_PER_BIT-1)) begin
                ph_d     = '0;
                acc_d    = '0;
                strobe_d = 1'b1;
`ifdef DEMOD_DIFFERENTIAL_EN
                bit_d    = decision ^ prev_q;
                prev_d   = decision;
`else
                bit_d    = decision;
`endif
            end else begin
                ph_d  = ph_q + PH_W'(1);
                acc_d = accSum;
            end
        end
    end

    // Sync hunt, payload collection and the single-entry output holding register.
    always_comb begin
        state_d   = state_q;
        sync_d    = sync_q;
        pkt_d     = pkt_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        deliver   = 1'b0;
        syncNext  = {sync_q[SYNC_WIDTH-2:0], bit_q};
        pktNext   = {pkt_q[PACKET_SIZE-2:0], bit_q};

        if (bus.resync) begin
            state_d = HUNT;
            sync_d  = '0;
            pkt_d   = '0;
            cnt_d   = '0;
        end else if (strobe_q) begin
            case (state_q)
                HUNT: begin
                    if (syncNext == SYNC_WORD) begin
                        state_d = COLLECT;
                        cnt_d   = '0;
                        sync_d  = '0;
                    end else begin
                        sync_d = syncNext;
                    end
                end
                COLLECT: begin
                    pkt_d = pktNext;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(PACKET_SIZE-1)) begin
                        deliver = 1'b1;
                        state_d = HUNT;
                        cnt_d   = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (deliver && (!valid_q || bus.packet_ready)) begin
            out_d   = pktNext;
            valid_d = 1'b1;
        end else if (deliver) begin
            overrun_d = 1'b1;
        end else if (valid_q && bus.packet_ready) begin
            valid_d = 1'b0;
        end
    end

    assign bus.packet_out   = out_q;
    assign bus.packet_valid = valid_q;
    assign bus.sync_locked  = (state_q == COLLECT);
    assign bus.overrun      = overrun_q;
endmodule
